ifu_fetch: RTL

//  Instruction fetch stage, directly upstream of the decode stage. Holds the PC, issues in-order

---
 rtl/ifu_fetch_pkg.sv | 23 ++
 rtl/ifu_fifo.sv | 79 +++++++
 rtl/ifu_fetch.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   NOP           : canonical no-op (addi x0,x0,0) shown to decode whenever
//                   no fetched instruction is available; decode uses the
//                   same encoding.
//   fetch_entry_t : one instruction-buffer entry {pc, instr}.
//   next_pc()     : sequential PC step, wraps at 2^32.
// ---------------------------------------------------------------------------
package ifu_fetch_pkg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo
// Synchronous instruction buffer of {pc, instr} entries with flush.
// Ports:
//   clk, rst      clock / synchronous active-high reset
//   push, wdata   write one entry (ignored when full unless popping too)
//   pop           remove head entry (ignored when empty)
//   flush         drop every entry; wins over push and pop
//   rdata         head entry (combinational from storage)
//   count         number of valid entries
//   empty, full   status flags
// DEPTH must be a power of two and >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ifu_fifo
   import ifu_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  fetch_entry_t     wdata,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     rdata,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign count   = count_q;
   assign rdata   = mem[rd_ptr];

   // A push into a full buffer is only accepted when the head leaves in the
   // same cycle, so a stray push can never overwrite an unread entry.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Storage carries no reset; validity is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch stage feeding decode. Holds the fetch PC, issues
// in-order word reads to instruction SRAM under a credit limit, buffers the
// returned words with their PC and presents one instruction per cycle.
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   jump_i, jump_addr_i      redirect from exu (highest priority)
//   hold_i                   exu load/store hold: head is not consumed
//   imem_req_o, imem_addr_o  SRAM read request and byte address
//   imem_gnt_i               request accepted this cycle
//   imem_rvalid_i/rdata_i    in-order read response
//   instr_o, pc_o            instruction for decode and its PC (NOP / 0
//                            when nothing valid)
//   instr_valid_o            instr_o is a real fetched instruction
//   misalign_o               one-cycle pulse on a misaligned jump target
// Configuration macro IFU_MISALIGN_CHK_EN enables misalign_o; without it the
// output is tied to 0. In both builds the jump target's low two bits are
// forced to 00.
// ---------------------------------------------------------------------------
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        instr_valid_o,
   output logic        misalign_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(FIFO_DEPTH);

   logic [31:0]      fetch_pc;
   logic [31:0]      resp_pc;
   logic [31:0]      jump_target;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] discard;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   used_credits;
   logic             fifo_empty;
   logic             fifo_full;
   logic             fifo_push;
   logic             fifo_pop;
   logic             issue;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;

   assign jump_target  = {jump_addr_i[31:2], 2'b00};

   // Every issued read owns a buffer slot until it is consumed, so the
   // buffer can never overflow no matter how responses bunch up.
   assign used_credits = {1'b0, fifo_count} + {1'b0, outstanding};
   assign imem_req_o   = ~rst & ~jump_i & (used_credits < CREDITS);
   assign imem_addr_o  = fetch_pc;
   assign issue        = imem_req_o & imem_gnt_i;

   // Responses come back in issue order, so the PC of the next kept response
   // is simply a second running counter rather than a stored PC list.
   assign fifo_push    = imem_rvalid_i & (discard == '0) & ~jump_i;
   assign push_entry   = '{pc: resp_pc, instr: imem_rdata_i};

   assign instr_valid_o = ~fifo_empty & ~jump_i;
   assign fifo_pop      = instr_valid_o & ~hold_i;
   assign instr_o       = instr_valid_o ? head.instr : NOP;
   assign pc_o          = instr_valid_o ? head.pc    : 32'h0;

   ifu_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (push_entry),
      .pop   (fifo_pop),
      .flush (jump_i),
      .rdata (head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // PC, credit and discard bookkeeping. On a jump, every read still in
   // flight after this cycle (a response arriving in the jump cycle itself
   // is dropped outright) must be thrown away when it returns.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else if (jump_i) begin
         fetch_pc    <= jump_target;
         resp_pc     <= jump_target;
         outstanding <= outstanding - CNT_W'(imem_rvalid_i);
         discard     <= outstanding - CNT_W'(imem_rvalid_i);
      end else begin
         if (issue) begin
            fetch_pc <= next_pc(fetch_pc);
         end
         outstanding <= outstanding + CNT_W'(issue) - CNT_W'(imem_rvalid_i);
         if (imem_rvalid_i) begin
            if (discard != '0) begin
               discard <= discard - CNT_W'(1);
            end else begin
               resp_pc <= next_pc(resp_pc);
            end
         end
      end
   end

`ifdef IFU_MISALIGN_CHK_EN
   logic misalign_q;
   logic unused_sink;

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= jump_i & (jump_addr_i[1:0] != 2'b00);
      end
   end

   assign misalign_o  = misalign_q;
   assign unused_sink = fifo_full;
`else
   logic unused_sink;

   assign misalign_o  = 1'b0;
   assign unused_sink = fifo_full ^ (^jump_addr_i[1:0]);
`endif

endmodule
